// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder/subtractor: carry chain split into STAGES chunks of W=N/STAGES bits.
// Latency STAGES cycles, one op per cycle; stalls ripple back through valid/ready, in_ready combinational from out_ready.
// Backpressure: a stage loads when it is empty or its content moves on; out_valid results held until out_ready.
module pipelined_adder_nbit #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // x holds {a bits not yet added, sum bits already produced}; y holds the
    // remaining b_eff chunks shifted down so the next chunk is always at [W-1:0].
    logic [N-1:0]      x_q  [STAGES];
    logic [N-1:0]      y_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v;
    logic              ovf_q;

    logic [N-1:0]      x_in [STAGES];
    logic [N-1:0]      y_in [STAGES];
    logic [N-1:0]      x_nx [STAGES];
    logic [N-1:0]      y_nx [STAGES];
    logic [W:0]        part [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES:0]   ld;
    logic              ovf_nx;

    // ld[k]: stage k register may capture new contents this edge
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !v[k] || ld[k+1];
        end
    end

    always_comb begin
        x_in[0] = a;
        y_in[0] = b ^ {N{sub}};
        c_in[0] = cin ^ sub;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            x_in[k] = x_q[k-1];
            y_in[k] = y_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, x_in[k][k*W +: W]} + {1'b0, y_in[k][W-1:0]} + {{W{1'b0}}, c_in[k]};
            x_nx[k] = x_in[k];
            x_nx[k][k*W +: W] = part[k][W-1:0];
            y_nx[k] = y_in[k] >> W;
        end
        // a's MSB is still untouched in x at the last stage; b_eff's MSB sits at y[W-1]
        ovf_nx = (x_in[L][N-1] == y_in[L][W-1]) && (part[L][W-1] != x_in[L][N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v[k] <= v_in[k];
                    if (v_in[k]) begin
                        x_q[k] <= x_nx[k];
                        y_q[k] <= y_nx[k];
                        c_q[k] <= part[k][W];
                    end
                end
            end
            if (ld[L] && v_in[L]) begin
                ovf_q <= ovf_nx;
            end
        end
    end

    assign in_ready  = !rst && ld[0];
    assign out_valid = v[L];
    assign sum       = x_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed cases on an 8/2 instance plus
// scoreboarded random traffic on 8/2, 16/4 and 8/1 instances.
module tb_pipelined_adder_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum[15:0]} from the whole-word formula
    function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [16:0] mask;
        logic [16:0] full;
        logic [15:0] beff;
        logic        c0;
        logic        ov;
        mask = (17'd1 << n) - 17'd1;
        beff = (b ^ {16{sub}}) & mask[15:0];
        c0   = cin ^ sub;
        full = {1'b0, a} + {1'b0, beff} + {16'd0, c0};
        ov   = (a[n-1] == beff[n-1]) && (full[n-1] != a[n-1]);
        return {ov, full[n], full[15:0] & mask[15:0]};
    endfunction

    // ---------------- directed instance (N=8, STAGES=2) ----------------
    logic       d_rst, d_in_valid, d_in_ready, d_cin, d_sub;
    logic       d_out_valid, d_out_ready, d_cout, d_ovf;
    logic [7:0] d_a, d_b, d_sum;

    pipelined_adder_nbit #(.N(8), .STAGES(2)) u_dir (
        .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
    );

    task automatic d_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
        @(posedge clk); #1;
        d_in_valid = 1'b1; d_a = a; d_b = b; d_cin = cin; d_sub = sub;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(d_in_ready), 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".early"}, 32'(d_out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(d_out_valid), 1);
        check({tag, ".sum"}, 32'(d_sum), 32'(es));
        check({tag, ".cout"}, 32'(d_cout), 32'(ec));
        check({tag, ".ovf"}, 32'(d_ovf), 32'(eo));
    endtask

    // ---------------- random instances ----------------
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int NN = (gi == 1) ? 16 : 8;
        localparam int SS = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);

        logic          r_rst, r_iv, r_ir, r_cin, r_sub, r_ov, r_or, r_cout, r_ovf;
        logic [NN-1:0] r_a, r_b, r_sum;
        logic [17:0]   sb[$];
        bit            done = 1'b0;

        pipelined_adder_nbit #(.N(NN), .STAGES(SS)) u_dut (
            .clk(clk), .rst(r_rst), .in_valid(r_iv), .in_ready(r_ir),
            .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub),
            .out_valid(r_ov), .out_ready(r_or),
            .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
        );

        task automatic observe(inout int acc);
            logic [17:0] exp;
            if (r_iv && r_ir) begin
                sb.push_back(model(NN, 16'(r_a), 16'(r_b), r_cin, r_sub));
                acc++;
            end
            if (r_ov && r_or) begin
                if (sb.size() == 0) begin
                    check($sformatf("rnd%0d.spurious", gi), 1, 0);
                end else begin
                    exp = sb.pop_front();
                    check($sformatf("rnd%0d.result", gi),
                          32'({r_ovf, r_cout, 16'(r_sum)}), 32'(exp));
                end
            end
        endtask

        initial begin
            int acc;
            int cyc;
            r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b0;
            r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
            acc = 0;
            cyc = 0;
            repeat (2) @(posedge clk);
            #1 r_rst = 1'b0;
            while (acc < 1000 && cyc < 20000) begin
                r_iv  = ($urandom_range(0, 9) < 7);
                r_a   = NN'($urandom);
                r_b   = NN'($urandom);
                r_cin = 1'($urandom);
                r_sub = 1'($urandom);
                r_or  = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                observe(acc);
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("rnd%0d.accepted", gi), 32'(acc), 1000);
            r_iv = 1'b0;
            r_or = 1'b1;
            cyc  = 0;
            while (cyc < 50) begin
                @(negedge clk);
                observe(acc);
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("rnd%0d.leftover", gi), 32'(sb.size()), 0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin
        logic [7:0] got[$];
        logic       acc3;
        logic       stale;
        int         w;

        d_rst = 1'b1; d_in_valid = 1'b1; d_a = 8'h55; d_b = 8'h11;
        d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 32'(d_out_valid), 0);
        check("rst.sum", 32'(d_sum), 0);
        check("rst.cout", 32'(d_cout), 0);
        check("rst.ovf", 32'(d_ovf), 0);
        check("rst.in_ready", 32'(d_in_ready), 0);
        @(posedge clk); #1;
        d_rst = 1'b0;
        d_in_valid = 1'b0;
        @(negedge clk);
        check("rel.in_ready", 32'(d_in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        check("rel.ignored", 32'(d_out_valid), 0);

        d_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        d_op("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        d_op("add_neg",  8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        d_op("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        d_op("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        d_op("sub_brw",  8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0);

        // backpressure: two fit, third stalls, head held
        @(posedge clk); #1;
        d_out_ready = 1'b0; d_in_valid = 1'b1; d_a = 8'd1; d_b = 8'd1; d_cin = 1'b0; d_sub = 1'b0;
        @(negedge clk);
        check("bp.acc1", 32'(d_in_ready), 1);
        @(posedge clk); #1;
        d_a = 8'd2; d_b = 8'd2;
        @(negedge clk);
        check("bp.acc2", 32'(d_in_ready), 1);
        @(posedge clk); #1;
        d_a = 8'd3; d_b = 8'd3;
        @(negedge clk);
        check("bp.full", 32'(d_in_ready), 0);
        check("bp.head_vld", 32'(d_out_valid), 1);
        check("bp.head", 32'(d_sum), 2);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("bp.hold", 32'(d_sum), 2);
        check("bp.still_full", 32'(d_in_ready), 0);
        @(posedge clk); #1;
        d_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc3 = d_in_valid && d_in_ready;
            if (d_out_valid && d_out_ready) got.push_back(d_sum);
            @(posedge clk); #1;
            if (acc3) d_in_valid = 1'b0;
        end
        check("bp.count", 32'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp.res%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                  32'(2 * (i + 1)));
        end

        // reset with two operations in flight
        @(posedge clk); #1;
        d_out_ready = 1'b0; d_in_valid = 1'b1; d_a = 8'h11; d_b = 8'h11;
        @(negedge clk);
        check("mid.acc1", 32'(d_in_ready), 1);
        @(posedge clk); #1;
        d_a = 8'h12; d_b = 8'h12;
        @(negedge clk);
        check("mid.acc2", 32'(d_in_ready), 1);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        d_rst = 1'b1;
        @(negedge clk);
        check("mid.in_ready", 32'(d_in_ready), 0);
        @(posedge clk); #1;
        d_rst = 1'b0;
        d_out_ready = 1'b1;
        @(negedge clk);
        check("mid.out_valid", 32'(d_out_valid), 0);
        check("mid.sum", 32'(d_sum), 0);
        check("mid.cout", 32'(d_cout), 0);
        check("mid.ovf", 32'(d_ovf), 0);
        stale = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (d_out_valid) stale = 1'b1;
        end
        check("mid.stale", 32'(stale), 0);
        d_op("mid.next", 8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);

        w = 0;
        while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && w < 40000) begin
            @(posedge clk);
            w++;
        end
        check("rnd.finished", 32'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
